gpu_pixel_sink: RTL and testbench

Downstream stage of the gpu core: consumes the pixel stream (x, y, r, g, b qualified by data_avail) and turns it into framebuffer memory writes. Pixels are buffered in a small FIFO so the core never stalls. A three-state write FSM computes the linear address `y*SCREEN_WIDTH + x` and holds a req/ack transaction to the framebuffer SRAM controller until it is acknowledged. FIFO overflow is flagged sticky, and dropped pixels are counted.

---
 rtl/gpu_pixel_sink.sv | 229 ++++++++++++++++++++++
 tb/tb_gpu_pixel_sink.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_pixel_sink.sv
// Purpose : pixel stream sink that buffers pixels and turns them into framebuffer SRAM writes.
// Latency : first request 2 cycles after the pixel is sampled (pop, then address calc); 1 pixel / 2 cycles sustained.
// Backpress: none toward the gpu core; a pixel arriving while the FIFO is full (and not popping) is dropped and counted.
//
// Ports:
//   clk, n_rst                      clock, synchronous active-low reset
//   x_i, y_i, r_i, g_i, b_i         pixel coordinate and colour, qualified by data_avail_i
//   mem_req_o/mem_addr_o/mem_wdata_o write request held until mem_ack_i
//   ovf_clr_i, overflow_o, drop_cnt_o sticky overflow flag and saturating drop counter
//   fifo_count_o, idle_o            buffer occupancy and quiescence status
//
// Build option: define PIXEL_CLIP_EN to discard off-screen pixels in CALC instead of
// writing them at a wrapped address.
module gpu_pixel_sink #(
    parameter int WIDTH_BITS    = 10,
    parameter int HEIGHT_BITS   = 9,
    parameter int CHANNEL_BITS  = 8,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int ADDR_BITS     = 19,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [WIDTH_BITS-1:0]         x_i,
    input  logic [HEIGHT_BITS-1:0]        y_i,
    input  logic [CHANNEL_BITS-1:0]       r_i,
    input  logic [CHANNEL_BITS-1:0]       g_i,
    input  logic [CHANNEL_BITS-1:0]       b_i,
    input  logic                          data_avail_i,
    output logic                          mem_req_o,
    output logic [ADDR_BITS-1:0]          mem_addr_o,
    output logic [3*CHANNEL_BITS-1:0]     mem_wdata_o,
    input  logic                          mem_ack_i,
    input  logic                          ovf_clr_i,
    output logic                          overflow_o,
    output logic [15:0]                   drop_cnt_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          idle_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = WIDTH_BITS + HEIGHT_BITS + 3 * CHANNEL_BITS;

    // Elaboration-time sanity check on the geometry parameters.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SCREEN_HEIGHT < 1)
    begin : g_param_check
        $error("gpu_pixel_sink: FIFO_DEPTH must be a power of two >= 2 and SCREEN_HEIGHT >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_REQ
    } state_e;

    // ------------------------------------------------------------------
    // Pixel FIFO
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic fifo_full, fifo_empty;
    logic push, pop, drop;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    // A pop on the same edge frees a slot, so a full FIFO still accepts the pixel.
    assign push = data_avail_i && (!fifo_full || pop);
    assign drop = data_avail_i && fifo_full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {x_i, y_i, r_i, g_i, b_i};
    end

    // ------------------------------------------------------------------
    // Write FSM and datapath
    // ------------------------------------------------------------------
    state_e state_q, state_d;

    logic [ENT_W-1:0]          pix_q, pix_d;
    logic [ADDR_BITS-1:0]      mem_addr_q, mem_addr_d;
    logic [3*CHANNEL_BITS-1:0] mem_wdata_q, mem_wdata_d;
    logic                      calc_en;

    logic [WIDTH_BITS-1:0]     pix_x;
    logic [HEIGHT_BITS-1:0]    pix_y;
    logic [CHANNEL_BITS-1:0]   pix_r, pix_g, pix_b;

    assign {pix_x, pix_y, pix_r, pix_g, pix_b} = pix_q;

`ifdef PIXEL_CLIP_EN
    logic offscreen;
    assign offscreen = (32'(pix_x) >= 32'(SCREEN_WIDTH)) ||
                       (32'(pix_y) >= 32'(SCREEN_HEIGHT));
`endif

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        calc_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
`ifdef PIXEL_CLIP_EN
                // Off-screen pixels skip the request and chain straight to the next pixel.
                if (offscreen) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_CALC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    calc_en = 1'b1;
                    state_d = ST_REQ;
                end
`else
                calc_en = 1'b1;
                state_d = ST_REQ;
`endif
            end
            ST_REQ: begin
                if (mem_ack_i) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_CALC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pix_d       = pix_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (pop) pix_d = fifo_mem_q[rd_ptr_q];
        if (calc_en) begin
            // Linear address wraps to ADDR_BITS when the coordinates are out of range.
            mem_addr_d  = ADDR_BITS'(32'(pix_y) * 32'(SCREEN_WIDTH) + 32'(pix_x));
            mem_wdata_d = {pix_r, pix_g, pix_b};
        end
    end

    // ------------------------------------------------------------------
    // Overflow flag and drop counter
    // ------------------------------------------------------------------
    logic        overflow_q, overflow_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            // A drop coinciding with a clear restarts the count at one.
            overflow_d = 1'b1;
            if (ovf_clr_i)
                drop_cnt_d = 16'd1;
            else if (drop_cnt_q != 16'hFFFF)
                drop_cnt_d = drop_cnt_q + 16'd1;
        end else if (ovf_clr_i) begin
            overflow_d = 1'b0;
            drop_cnt_d = 16'd0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pix_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pix_q       <= pix_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign mem_req_o    = (state_q == ST_REQ);
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign overflow_o   = overflow_q;
    assign drop_cnt_o   = drop_cnt_q;
    assign fifo_count_o = count_q;
    assign idle_o       = fifo_empty && (state_q == ST_IDLE);

endmodule

// File: tb/tb_gpu_pixel_sink.sv
// Purpose : directed self-checking bench for gpu_pixel_sink.
// Latency : checks the 2-cycle pixel-to-request path and 1-cycle ack-to-release.
// Backpress: a negedge responder acks requests after a programmable delay and logs writes.
module tb_gpu_pixel_sink;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [9:0]  x_i;
    logic [8:0]  y_i;
    logic [7:0]  r_i, g_i, b_i;
    logic        data_avail_i;
    logic        mem_req_o;
    logic [18:0] mem_addr_o;
    logic [23:0] mem_wdata_o;
    logic        mem_ack_i;
    logic        ovf_clr_i;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;
    logic [3:0]  fifo_count_o;
    logic        idle_o;

    int n_checks = 0;
    int n_errors = 0;

    // Responder state
    logic        resp_en  = 1'b0;
    logic        resp_ack = 1'b0;
    logic        man_ack  = 1'b0;
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    logic [18:0] wr_addr[$];
    logic [23:0] wr_data[$];

    assign mem_ack_i = resp_en ? resp_ack : man_ack;

    always #5 clk = ~clk;

    gpu_pixel_sink dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .x_i          (x_i),
        .y_i          (y_i),
        .r_i          (r_i),
        .g_i          (g_i),
        .b_i          (b_i),
        .data_avail_i (data_avail_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .ovf_clr_i    (ovf_clr_i),
        .overflow_o   (overflow_o),
        .drop_cnt_o   (drop_cnt_o),
        .fifo_count_o (fifo_count_o),
        .idle_o       (idle_o)
    );

    // Acks a held request after ack_delay negedges and logs the write it accepts.
    always @(negedge clk) begin
        if (resp_en && n_rst && mem_req_o && !resp_ack) begin
            if (wait_cnt >= ack_delay) begin
                resp_ack = 1'b1;
                wait_cnt = 0;
                wr_addr.push_back(mem_addr_o);
                wr_data.push_back(mem_wdata_o);
            end else begin
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            resp_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pixel i of the directed set: x=7i+3, y=i+1, r=16i+1, g=i+0x40, b=i+0xA0.
    function automatic logic [18:0] exp_addr(input int i);
        return 19'((i + 1) * 640 + i * 7 + 3);
    endfunction

    function automatic logic [23:0] exp_data(input int i);
        return {8'(i * 16 + 1), 8'(i + 8'h40), 8'(i + 8'hA0)};
    endfunction

    // Presents pixel i for exactly one edge, returning at the following negedge.
    task automatic drive_pix(input int i);
        x_i          = 10'(i * 7 + 3);
        y_i          = 9'(i + 1);
        r_i          = 8'(i * 16 + 1);
        g_i          = 8'(i + 8'h40);
        b_i          = 8'(i + 8'hA0);
        data_avail_i = 1'b1;
        @(negedge clk);
        data_avail_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n = 0;
        while (!idle_o && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(idle_o), 32'd1);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        int peak;
        n_rst        = 1'b0;
        x_i          = '0;
        y_i          = '0;
        r_i          = '0;
        g_i          = '0;
        b_i          = '0;
        data_avail_i = 1'b0;
        ovf_clr_i    = 1'b0;

        // ---------------- Reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_req",   32'(mem_req_o),    32'd0);
        chk("rst_addr",  32'(mem_addr_o),   32'd0);
        chk("rst_wdata", 32'(mem_wdata_o),  32'd0);
        chk("rst_ovf",   32'(overflow_o),   32'd0);
        chk("rst_drop",  32'(drop_cnt_o),   32'd0);
        chk("rst_count", 32'(fifo_count_o), 32'd0);
        chk("rst_idle",  32'(idle_o),       32'd1);
        n_rst = 1'b1;
        @(negedge clk);

        // ---------------- Single pixel, ack tied high ----------------
        man_ack      = 1'b1;
        x_i          = 10'd3;
        y_i          = 9'd2;
        r_i          = 8'h11;
        g_i          = 8'h22;
        b_i          = 8'h33;
        data_avail_i = 1'b1;
        @(negedge clk);                     // E0 sampled
        data_avail_i = 1'b0;
        chk("sp_cnt_e0",  32'(fifo_count_o), 32'd1);
        chk("sp_req_e0",  32'(mem_req_o),    32'd0);
        @(negedge clk);                     // E1: pop into CALC
        chk("sp_cnt_e1",  32'(fifo_count_o), 32'd0);
        chk("sp_req_e1",  32'(mem_req_o),    32'd0);
        @(negedge clk);                     // E2: request up
        chk("sp_req_e2",  32'(mem_req_o),    32'd1);
        chk("sp_addr",    32'(mem_addr_o),   32'd1283);
        chk("sp_wdata",   32'(mem_wdata_o),  32'h112233);
        @(negedge clk);                     // E3: ack sampled
        chk("sp_req_e3",  32'(mem_req_o),    32'd0);
        chk("sp_idle_e3", 32'(idle_o),       32'd1);
        man_ack = 1'b0;

        // ---------------- Burst of 8, ack delayed 5 ----------------
        clear_log();
        resp_en   = 1'b1;
        ack_delay = 5;
        peak      = 0;
        for (int i = 0; i < 8; i++) begin
            drive_pix(i);
            if (int'(fifo_count_o) > peak) peak = int'(fifo_count_o);
        end
        wait_idle("burst_idle", 300);
        chk("burst_peak",   32'(peak),           32'd7);
        chk("burst_nwr",    32'(wr_addr.size()), 32'd8);
        for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
            chk($sformatf("burst_addr%0d", i), 32'(wr_addr[i]), 32'(exp_addr(i)));
            chk($sformatf("burst_data%0d", i), 32'(wr_data[i]), 32'(exp_data(i)));
        end
        chk("burst_ovf",    32'(overflow_o),     32'd0);

        // ---------------- Overflow, ack held low ----------------
        resp_en = 1'b0;
        man_ack = 1'b0;
        for (int i = 0; i < 10; i++) drive_pix(20 + i);
        chk("ovf_count", 32'(fifo_count_o), 32'd8);
        chk("ovf_drop",  32'(drop_cnt_o),   32'd1);
        chk("ovf_flag",  32'(overflow_o),   32'd1);
        chk("ovf_req",   32'(mem_req_o),    32'd1);
        chk("ovf_addr",  32'(mem_addr_o),   32'(exp_addr(20)));
        drive_pix(30);
        chk("ovf_drop2", 32'(drop_cnt_o),   32'd2);
        // Clear and drop on the same edge: drop wins.
        ovf_clr_i = 1'b1;
        drive_pix(31);
        chk("clr_drop_cnt", 32'(drop_cnt_o), 32'd1);
        chk("clr_drop_ovf", 32'(overflow_o), 32'd1);
        @(negedge clk);
        ovf_clr_i = 1'b0;
        chk("clr_cnt",   32'(drop_cnt_o),   32'd0);
        chk("clr_ovf",   32'(overflow_o),   32'd0);

        // ---------------- Full FIFO with simultaneous pop ----------------
        man_ack = 1'b1;
        drive_pix(32);
        man_ack = 1'b0;
        chk("fp_count", 32'(fifo_count_o), 32'd8);
        chk("fp_drop",  32'(drop_cnt_o),   32'd0);
        chk("fp_ovf",   32'(overflow_o),   32'd0);
        chk("fp_req",   32'(mem_req_o),    32'd0);
        @(negedge clk);
        chk("fp_req2",  32'(mem_req_o),    32'd1);
        chk("fp_addr2", 32'(mem_addr_o),   32'(exp_addr(21)));

        // Drain: expect pixels 21..28 then 32 (29..31 were dropped).
        clear_log();
        ack_delay = 0;
        resp_en   = 1'b1;
        wait_idle("drain_idle", 300);
        chk("drain_nwr", 32'(wr_addr.size()), 32'd9);
        for (int i = 0; i < 9 && i < wr_addr.size(); i++) begin
            int p;
            p = (i < 8) ? 21 + i : 32;
            chk($sformatf("drain_addr%0d", i), 32'(wr_addr[i]), 32'(exp_addr(p)));
        end

        // ---------------- Off-screen x ----------------
        clear_log();
        x_i          = 10'd640;
        y_i          = 9'd0;
        r_i          = 8'h01;
        g_i          = 8'h02;
        b_i          = 8'h03;
        data_avail_i = 1'b1;
        @(negedge clk);
        data_avail_i = 1'b0;
        @(negedge clk);
        wait_idle("clip_idle", 50);
`ifdef PIXEL_CLIP_EN
        chk("clip_nwr",  32'(wr_addr.size()), 32'd0);
`else
        chk("clip_nwr",  32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() > 0) chk("clip_addr", 32'(wr_addr[0]), 32'd640);
`endif

        // ---------------- Reset mid-request ----------------
        resp_en = 1'b0;
        man_ack = 1'b0;
        for (int i = 0; i < 4; i++) drive_pix(40 + i);
        @(negedge clk);
        chk("mr_req_pre",   32'(mem_req_o),    32'd1);
        chk("mr_count_pre", 32'(fifo_count_o), 32'd3);
        n_rst = 1'b0;
        @(negedge clk);
        chk("mr_req",   32'(mem_req_o),    32'd0);
        chk("mr_count", 32'(fifo_count_o), 32'd0);
        chk("mr_idle",  32'(idle_o),       32'd1);
        n_rst = 1'b1;
        clear_log();
        resp_en = 1'b1;
        repeat (10) @(negedge clk);
        chk("mr_nwr",   32'(wr_addr.size()), 32'd0);
        chk("mr_idle2", 32'(idle_o),         32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
